// File: rtl/wb_io_event_sampler_if.sv
// ---------------------------------------------------------------------------
// wb_io_event_sampler_if
// Wishbone classic slave-side bus bundle for the io_in event sampler.
//   wbs_cyc_i  bus cycle           wbs_stb_i  strobe
//   wbs_we_i   1 = write           wbs_sel_i  byte enables [3:0]
//   wbs_adr_i  byte address [31:0] wbs_dat_i  write data [31:0]
//   wbs_ack_o  acknowledge         wbs_dat_o  read data [31:0]
// The master modport drives requests; the slave modport answers them.
// ---------------------------------------------------------------------------
interface wb_io_event_sampler_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_io_event_sampler.sv
// ---------------------------------------------------------------------------
// wb_io_event_sampler
// Wishbone classic responder that samples externally driven user I/O pins
// (io_in[37:33]), synchronises them, detects enabled rising/falling edges,
// keeps sticky per-pin event flags plus a saturating event count, and raises
// an interrupt when an enabled flag is set.
// Ports:
//   wb_clk_i   sole clock
//   wb_rst_ni  asynchronous active-low reset
//   wb         Wishbone slave bundle (cyc/stb/we/sel/adr/dat in, ack/dat out)
//   pins_i     asynchronous pin inputs [NPINS-1:0]
//   irq_o      interrupt, high while any enabled STATUS bit is set
// Register map (offset from BASE_ADDR, selected by adr[4:2]):
//   0x00 IN RO, 0x04 RISE RW, 0x08 FALL RW, 0x0C STATUS W1C,
//   0x10 IRQEN RW, 0x14 COUNT (write with sel[0]|sel[1] clears),
//   0x18/0x1C read 0, writes ignored.
// ---------------------------------------------------------------------------
module wb_io_event_sampler #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0100,
    parameter int          NPINS       = 5,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    wb_io_event_sampler_if.slave wb,
    input  logic [NPINS-1:0]     pins_i,
    output logic                 irq_o
);

    localparam int PRIME_MAX = SYNC_STAGES + 1;
    localparam int PW        = $clog2(PRIME_MAX + 1);

    localparam logic [2:0] REG_IN     = 3'd0;
    localparam logic [2:0] REG_RISE   = 3'd1;
    localparam logic [2:0] REG_FALL   = 3'd2;
    localparam logic [2:0] REG_STATUS = 3'd3;
    localparam logic [2:0] REG_IRQEN  = 3'd4;
    localparam logic [2:0] REG_COUNT  = 3'd5;

    logic [SYNC_STAGES-1:0][NPINS-1:0] sync_q, sync_d;
    logic [NPINS-1:0] prev_q, prev_d;
    logic [NPINS-1:0] rise_en_q, rise_en_d;
    logic [NPINS-1:0] fall_en_q, fall_en_d;
    logic [NPINS-1:0] status_q, status_d;
    logic [NPINS-1:0] irq_en_q, irq_en_d;
    logic [15:0]      count_q, count_d;
    logic [PW-1:0]    prime_q, prime_d;
    logic             ack_q, ack_d;
    logic [31:0]      dat_q, dat_d;

    logic [NPINS-1:0] sync_val;
    logic [NPINS-1:0] ev_pins;
    logic             any_ev;
    logic             primed;
    logic             hit;
    logic             req;
    logic             wr;
    logic [2:0]       reg_sel;
    logic [NPINS-1:0] sel_mask;
    logic [NPINS-1:0] wdata_n;
    logic [NPINS-1:0] w1c_mask;
    logic             count_clr;
    logic [31:0]      rdata;

    // Address bits below the word select, the alias bits inside the window
    // and any data/sel bits beyond the implemented pins carry no meaning here.
    logic unused_bus;
    assign unused_bus = ^{wb.wbs_adr_i[7:5], wb.wbs_adr_i[1:0], wb.wbs_dat_i, wb.wbs_sel_i};

    function automatic logic [31:0] widen(input logic [NPINS-1:0] v);
        logic [31:0] r;
        r            = '0;
        r[NPINS-1:0] = v;
        return r;
    endfunction

    assign sync_val = sync_q[SYNC_STAGES-1];
    assign primed   = (prime_q == PW'(PRIME_MAX));

    // Edges are only believed once the synchroniser and prev register hold
    // genuine post-reset samples; otherwise a pin already high at reset
    // release would look like a rising edge.
    always_comb begin
        ev_pins = '0;
        if (primed) begin
            ev_pins = (sync_val & ~prev_q & rise_en_q) | (~sync_val & prev_q & fall_en_q);
        end
        any_ev = |ev_pins;
    end

    // Bus decode: a request is only taken while ack is low, so a held strobe
    // is answered on alternate cycles.
    always_comb begin
        hit     = (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
        req     = wb.wbs_cyc_i & wb.wbs_stb_i & hit & ~ack_q;
        wr      = req & wb.wbs_we_i;
        reg_sel = wb.wbs_adr_i[4:2];
        wdata_n = wb.wbs_dat_i[NPINS-1:0];
        for (int i = 0; i < NPINS; i++) begin
            sel_mask[i] = wb.wbs_sel_i[i/8];
        end
    end

    // Read multiplexer; unimplemented offsets and bits above NPINS read 0.
    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_IN:     rdata = widen(sync_val);
            REG_RISE:   rdata = widen(rise_en_q);
            REG_FALL:   rdata = widen(fall_en_q);
            REG_STATUS: rdata = widen(status_q);
            REG_IRQEN:  rdata = widen(irq_en_q);
            REG_COUNT:  rdata = {16'h0000, count_q};
            default:    rdata = '0;
        endcase
    end

    // Next-state logic for synchroniser, prime counter, registers and bus.
    // An edge landing in the same cycle as a W1C or COUNT clear survives it.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = pins_i;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        prev_d  = sync_val;
        prime_d = primed ? prime_q : prime_q + PW'(1);

        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        irq_en_d  = irq_en_q;
        if (wr && reg_sel == REG_RISE) begin
            rise_en_d = (rise_en_q & ~sel_mask) | (wdata_n & sel_mask);
        end
        if (wr && reg_sel == REG_FALL) begin
            fall_en_d = (fall_en_q & ~sel_mask) | (wdata_n & sel_mask);
        end
        if (wr && reg_sel == REG_IRQEN) begin
            irq_en_d = (irq_en_q & ~sel_mask) | (wdata_n & sel_mask);
        end

        w1c_mask = '0;
        if (wr && reg_sel == REG_STATUS) begin
            w1c_mask = wdata_n & sel_mask;
        end
        status_d = (status_q & ~w1c_mask) | ev_pins;

        count_clr = wr && (reg_sel == REG_COUNT) && (wb.wbs_sel_i[0] || wb.wbs_sel_i[1]);
        count_d   = count_q;
        if (count_clr) begin
            count_d = any_ev ? 16'd1 : 16'd0;
        end else if (any_ev && count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
        end

        ack_d = req;
        dat_d = (req && !wb.wbs_we_i) ? rdata : '0;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sync_q    <= '0;
            prev_q    <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            irq_en_q  <= '0;
            count_q   <= '0;
            prime_q   <= '0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            irq_en_q  <= irq_en_d;
            count_q   <= count_d;
            prime_q   <= prime_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
        end
    end

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = dat_q;
    assign irq_o        = |(status_q & irq_en_q);

endmodule

// File: tb/tb_wb_io_event_sampler.sv
// ---------------------------------------------------------------------------
// tb_wb_io_event_sampler
// Self-checking bench: a table of register vectors, hand-written sequences
// for the multi-cycle corner cases, a randomized phase and a saturation run,
// with a delay-line reference model of the pin/edge/register behaviour.
// ---------------------------------------------------------------------------
module tb_wb_io_event_sampler;

    localparam logic [31:0] BASE  = 32'h3000_0100;
    localparam int          NPINS = 5;
    localparam int          S     = 2;

    localparam logic [31:0] O_IN     = 32'h00;
    localparam logic [31:0] O_RISE   = 32'h04;
    localparam logic [31:0] O_FALL   = 32'h08;
    localparam logic [31:0] O_STATUS = 32'h0C;
    localparam logic [31:0] O_IRQEN  = 32'h10;
    localparam logic [31:0] O_COUNT  = 32'h14;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NPINS-1:0] pins = '0;
    logic             irq;

    int checks = 0;
    int errors = 0;
    bit modelCheck = 1'b1;

    wb_io_event_sampler_if wbif();

    wb_io_event_sampler #(
        .BASE_ADDR  (BASE),
        .NPINS      (NPINS),
        .SYNC_STAGES(S)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .wb       (wbif),
        .pins_i   (pins),
        .irq_o    (irq)
    );

    always #5 clk = ~clk;

    // Reference model state: registers plus a short history of sampled pins.
    logic             m_ack;
    logic [31:0]      m_rdata;
    logic [NPINS-1:0] m_rise, m_fall, m_status, m_irqen;
    logic [15:0]      m_count;
    int               m_edges;
    logic [NPINS-1:0] hist[$];

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] wdat;
        logic        expAck;
        logic [31:0] expDat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkVec(logic we, logic [31:0] adr, logic [3:0] sel,
                                   logic [31:0] wdat, logic expAck, logic [31:0] expDat);
        vec_t v;
        v.we = we; v.adr = adr; v.sel = sel; v.wdat = wdat;
        v.expAck = expAck; v.expDat = expDat;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        m_ack = 1'b0; m_rdata = '0;
        m_rise = '0; m_fall = '0; m_status = '0; m_irqen = '0;
        m_count = '0; m_edges = 0;
        hist.delete();
        repeat (S + 2) hist.push_back('0);
    endtask

    // One clock of the model. The synchronised level seen before an edge is
    // the pin value sampled S edges earlier; the previous level is one older.
    task automatic modelStep();
        logic [NPINS-1:0] syncV, prevV, ev, w1c;
        logic [31:0]      rd, bm;
        logic             hit, req, clr;
        logic [2:0]       idx;
        int               n;
        n     = hist.size();
        syncV = hist[n-S];
        prevV = hist[n-S-1];
        ev    = '0;
        if (m_edges >= S + 1) ev = (syncV & ~prevV & m_rise) | (~syncV & prevV & m_fall);
        hit = (wbif.wbs_adr_i[31:8] == BASE[31:8]);
        req = wbif.wbs_cyc_i && wbif.wbs_stb_i && hit && !m_ack;
        idx = wbif.wbs_adr_i[4:2];
        bm  = {{8{wbif.wbs_sel_i[3]}}, {8{wbif.wbs_sel_i[2]}},
               {8{wbif.wbs_sel_i[1]}}, {8{wbif.wbs_sel_i[0]}}};
        case (idx)
            3'd0:    rd = 32'(syncV);
            3'd1:    rd = 32'(m_rise);
            3'd2:    rd = 32'(m_fall);
            3'd3:    rd = 32'(m_status);
            3'd4:    rd = 32'(m_irqen);
            3'd5:    rd = 32'(m_count);
            default: rd = '0;
        endcase
        m_rdata = (req && !wbif.wbs_we_i) ? rd : 32'h0;
        w1c = '0;
        clr = 1'b0;
        if (req && wbif.wbs_we_i) begin
            case (idx)
                3'd1: m_rise  = NPINS'((32'(m_rise)  & ~bm) | (wbif.wbs_dat_i & bm));
                3'd2: m_fall  = NPINS'((32'(m_fall)  & ~bm) | (wbif.wbs_dat_i & bm));
                3'd3: w1c     = NPINS'(wbif.wbs_dat_i & bm);
                3'd4: m_irqen = NPINS'((32'(m_irqen) & ~bm) | (wbif.wbs_dat_i & bm));
                3'd5: clr     = wbif.wbs_sel_i[0] || wbif.wbs_sel_i[1];
                default: ;
            endcase
        end
        m_ack    = req;
        m_status = (m_status & ~w1c) | ev;
        if (clr) m_count = (ev != 0) ? 16'd1 : 16'd0;
        else if (ev != 0 && m_count != 16'hFFFF) m_count = m_count + 16'd1;
        hist.push_back(pins);
        if (hist.size() > S + 2) void'(hist.pop_front());
        if (m_edges < 1000) m_edges++;
    endtask

    task automatic tick();
        if (rst_n) modelStep();
        @(posedge clk);
        #1;
        if (modelCheck) begin
            checkOutput("model_ack", 32'(wbif.wbs_ack_o), 32'(m_ack));
            checkOutput("model_dat", wbif.wbs_dat_o, m_rdata);
            checkOutput("model_irq", 32'(irq), 32'(|(m_status & m_irqen)));
        end
    endtask

    task automatic busIdle();
        wbif.wbs_cyc_i = 1'b0; wbif.wbs_stb_i = 1'b0; wbif.wbs_we_i = 1'b0;
        wbif.wbs_sel_i = 4'h0; wbif.wbs_adr_i = '0;   wbif.wbs_dat_i = '0;
    endtask

    task automatic busDrive(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                            input logic [31:0] dat);
        wbif.wbs_cyc_i = 1'b1; wbif.wbs_stb_i = 1'b1; wbif.wbs_we_i = we;
        wbif.wbs_sel_i = sel;  wbif.wbs_adr_i = adr;  wbif.wbs_dat_i = dat;
    endtask

    task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                                 input logic [31:0] dat, output logic ackSeen,
                                 output logic [31:0] rdat);
        busDrive(we, adr, sel, dat);
        tick();
        ackSeen = wbif.wbs_ack_o;
        rdat    = wbif.wbs_dat_o;
        busIdle();
        tick();
    endtask

    task automatic writeReg(input string name, input logic [31:0] off, input logic [31:0] dat,
                            input logic [3:0] sel);
        logic a; logic [31:0] d;
        applyStimulus(1'b1, BASE + off, sel, dat, a, d);
        checkOutput({name, "_ack"}, 32'(a), 32'd1);
    endtask

    task automatic readReg(input string name, input logic [31:0] off, input logic [31:0] exp);
        logic a; logic [31:0] d;
        applyStimulus(1'b0, BASE + off, 4'hF, 32'h0, a, d);
        checkOutput({name, "_ack"}, 32'(a), 32'd1);
        checkOutput(name, d, exp);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        busIdle();
        modelReset();
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rst_ack", 32'(wbif.wbs_ack_o), 32'd0);
        checkOutput("rst_dat", wbif.wbs_dat_o, 32'd0);
        checkOutput("rst_irq", 32'(irq), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic        a;
        logic [31:0] d;
        logic [31:0] adr;

        busIdle();
        $display("[TB] start");

        // Register table, pins idle low
        pins = '0;
        doReset();
        for (int i = 0; i < 8; i++) vecs.push_back(mkVec(1'b0, BASE + 32'(i * 4), 4'hF, 0, 1'b1, 0));
        vecs.push_back(mkVec(1'b0, 32'h3000_0200, 4'hF, 0,            1'b0, 0));
        vecs.push_back(mkVec(1'b1, 32'h3000_0204, 4'hF, 32'hFFFF_FFFF, 1'b0, 0));
        vecs.push_back(mkVec(1'b1, BASE + O_RISE, 4'b0010, 32'hFFFF_FFFF, 1'b1, 0));
        vecs.push_back(mkVec(1'b0, BASE + O_RISE, 4'hF, 0,            1'b1, 0));
        vecs.push_back(mkVec(1'b1, BASE + O_RISE, 4'b0001, 32'hFFFF_FFFF, 1'b1, 0));
        vecs.push_back(mkVec(1'b0, BASE + 32'h07, 4'hF, 0,            1'b1, 32'h1F));
        vecs.push_back(mkVec(1'b1, BASE + O_FALL, 4'hF, 32'h0000_00AB, 1'b1, 0));
        vecs.push_back(mkVec(1'b0, BASE + O_FALL, 4'hF, 0,            1'b1, 32'h0B));
        vecs.push_back(mkVec(1'b1, BASE + O_IRQEN, 4'hF, 32'h15,      1'b1, 0));
        vecs.push_back(mkVec(1'b0, BASE + O_IRQEN, 4'hF, 0,           1'b1, 32'h15));
        vecs.push_back(mkVec(1'b1, BASE + O_IN, 4'hF, 32'hFF,         1'b1, 0));
        vecs.push_back(mkVec(1'b0, BASE + O_IN, 4'hF, 0,              1'b1, 0));
        vecs.push_back(mkVec(1'b1, BASE + 32'h18, 4'hF, 32'hFFFF_FFFF, 1'b1, 0));
        vecs.push_back(mkVec(1'b0, BASE + 32'h18, 4'hF, 0,            1'b1, 0));
        vecs.push_back(mkVec(1'b1, BASE + O_STATUS, 4'hF, 32'h1F,     1'b1, 0));
        vecs.push_back(mkVec(1'b0, BASE + O_STATUS, 4'hF, 0,          1'b1, 0));
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].wdat, a, d);
            checkOutput($sformatf("vec%0d_ack", i), 32'(a), 32'(vecs[i].expAck));
            if (!vecs[i].we) checkOutput($sformatf("vec%0d_dat", i), d, vecs[i].expDat);
        end

        // Pin already high through reset release must not register an edge
        pins = 5'b00001;
        doReset();
        writeReg("prime_rise", O_RISE, 32'h1, 4'hF);
        repeat (8) tick();
        readReg("prime_status", O_STATUS, 32'h0);
        readReg("prime_count", O_COUNT, 32'h0);
        readReg("prime_in", O_IN, 32'h1);

        // Rising edge latency and irq, then W1C
        pins = '0;
        doReset();
        writeReg("lat_rise", O_RISE, 32'h1, 4'hF);
        writeReg("lat_irqen", O_IRQEN, 32'h1, 4'hF);
        repeat (2) tick();
        pins = 5'b00001;
        tick(); checkOutput("lat_irq_n1", 32'(irq), 32'd0);
        tick(); checkOutput("lat_irq_n2", 32'(irq), 32'd0);
        tick(); checkOutput("lat_irq_n3", 32'(irq), 32'd1);
        readReg("lat_status", O_STATUS, 32'h1);
        busDrive(1'b1, BASE + O_STATUS, 4'hF, 32'h1);
        tick(); checkOutput("w1c_irq", 32'(irq), 32'd0);
        busIdle(); tick();

        // Two pins falling together count as one event
        writeReg("fall_en", O_FALL, 32'h1F, 4'hF);
        pins = 5'b10101;
        repeat (5) tick();
        writeReg("fall_clr", O_COUNT, 32'h0, 4'b0001);
        readReg("fall_count0", O_COUNT, 32'h0);
        pins = 5'b00001;
        repeat (5) tick();
        readReg("fall_status", O_STATUS, 32'h14);
        readReg("fall_count1", O_COUNT, 32'h1);

        // W1C coinciding with a new edge on the same pin: the edge wins
        pins = 5'b00000;
        tick(); tick();
        busDrive(1'b1, BASE + O_STATUS, 4'hF, 32'h1);
        tick(); checkOutput("setwins_irq", 32'(irq), 32'd1);
        busIdle(); tick();
        readReg("setwins_status", O_STATUS, 32'h15);

        // COUNT clear coinciding with an event leaves COUNT at 1
        pins = 5'b00001;
        tick(); tick();
        busDrive(1'b1, BASE + O_COUNT, 4'b0010, 32'h0);
        tick();
        busIdle(); tick();
        readReg("clrwins_count", O_COUNT, 32'h1);

        // Held strobe acks on alternate cycles
        busDrive(1'b0, BASE + O_IN, 4'hF, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("held_ack%0d", i), 32'(wbif.wbs_ack_o), 32'((i % 2) == 0));
        end
        busIdle(); tick();

        // Reset during an acked transfer drops ack at once
        busDrive(1'b0, BASE + O_STATUS, 4'hF, 32'h0);
        tick();
        checkOutput("midrst_ack_before", 32'(wbif.wbs_ack_o), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_ack", 32'(wbif.wbs_ack_o), 32'd0);
        checkOutput("midrst_irq", 32'(irq), 32'd0);

        // Randomized traffic against the model
        pins = NPINS'($urandom);
        doReset();
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 1) == 1) pins = NPINS'($urandom);
            adr = BASE + {27'd0, 3'($urandom_range(0, 7)), 2'($urandom)};
            if ($urandom_range(0, 7) == 0) adr = adr + 32'h100;
            applyStimulus(1'($urandom), adr, 4'($urandom), $urandom, a, d);
            repeat ($urandom_range(0, 2)) begin
                if ($urandom_range(0, 3) == 0) pins = NPINS'($urandom);
                tick();
            end
        end
        for (int r = 1; r < 6; r++) readReg($sformatf("rand_final%0d", r), 32'(r * 4),
            (r == 1) ? 32'(m_rise) : (r == 2) ? 32'(m_fall) : (r == 3) ? 32'(m_status) :
            (r == 4) ? 32'(m_irqen) : 32'(m_count));

        // COUNT saturates at 16'hFFFF
        pins = '0;
        doReset();
        writeReg("sat_rise", O_RISE, 32'h1, 4'hF);
        writeReg("sat_fall", O_FALL, 32'h1, 4'hF);
        modelCheck = 1'b0;
        for (int i = 0; i < 65600; i++) begin
            pins[0] = ~pins[0];
            tick();
        end
        repeat (4) tick();
        modelCheck = 1'b1;
        readReg("sat_count", O_COUNT, 32'h0000_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
